// File: rtl/voting_pkg.sv
// Shared types and helpers for the ballot tally block.
package voting_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, DONE} state_t;

   localparam int ONEHOT_MAX_W = 64;

   // Zero-extension preserves one-hotness, so any width up to ONEHOT_MAX_W works.
   function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
      return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/tally_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module tally_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    count <= '0;
      else if (clr)                  count <= '0;
      else if (inc && count != '1)   count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/voting_tally.sv
// Serial one-hot ballot collector: per-candidate tallies, then a one-candidate-per-cycle
// scan picks the winner (highest index wins ties).
module voting_tally
   import voting_pkg::*;
#(
   parameter int NUM_CAND = 3,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                ballot_valid,
   input  logic [NUM_CAND-1:0] ballot,
   output logic                ballot_ready,
   input  logic                close,
   output logic [NUM_CAND-1:0] winner,
   output logic [CNT_W-1:0]    winner_count,
   output logic                tie,
   output logic [CNT_W-1:0]    invalid_count,
   output logic                done
);

   // One extra index value marks "scan finished" so the result registers one cycle later.
   localparam int IDX_W = $clog2(NUM_CAND + 1);

   state_t                             state, state_nxt;
   logic                               clr, hs, valid_vote, inv_inc, scan_last;
   logic [NUM_CAND-1:0]                tally_inc, win_onehot;
   logic [NUM_CAND-1:0][CNT_W-1:0]     tally;
   logic [CNT_W-1:0]                   inv_cnt, cur, best_max;
   logic [IDX_W-1:0]                   scan_idx, best_idx;
   logic                               best_tie;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      case (state)
         IDLE:    if (start) begin state_nxt = COLLECT; clr = 1'b1; end
         COLLECT: if (start) clr = 1'b1;
                  else if (close) state_nxt = RESOLVE;
         RESOLVE: if (scan_last) state_nxt = DONE;
         DONE:    if (start) begin state_nxt = COLLECT; clr = 1'b1; end
         default: state_nxt = IDLE;
      endcase
   end

   // A restart in COLLECT drops the same-cycle ballot.
   assign hs         = (state == COLLECT) && ballot_valid && ballot_ready && !start;
   assign valid_vote = is_onehot(ONEHOT_MAX_W'(ballot));
   assign tally_inc  = (hs && valid_vote) ? ballot : '0;
   assign inv_inc    = hs && !valid_vote;
   assign scan_last  = (scan_idx == IDX_W'(NUM_CAND));

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
      tally_counter #(.CNT_W(CNT_W)) u_tally (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .inc   (tally_inc[g]),
         .count (tally[g])
      );
   end

   tally_counter #(.CNT_W(CNT_W)) u_invalid (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inv_inc),
      .count (inv_cnt)
   );

   always_comb begin
      cur        = '0;
      win_onehot = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (scan_idx == IDX_W'(i)) cur = tally[i];
         win_onehot[i] = (best_max != '0) && (best_idx == IDX_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx <= '0;
         best_max <= '0;
         best_idx <= '0;
         best_tie <= 1'b0;
      end else if (state == COLLECT) begin
         scan_idx <= '0;
         best_max <= '0;
         best_idx <= '0;
         best_tie <= 1'b0;
      end else if (state == RESOLVE && !scan_last) begin
         scan_idx <= scan_idx + IDX_W'(1);
         if (cur > best_max) begin
            best_max <= cur;
            best_idx <= scan_idx;
            best_tie <= 1'b0;
         end else if (cur == best_max && best_max != '0) begin
            best_idx <= scan_idx;
            best_tie <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ballot_ready  <= 1'b0;
         done          <= 1'b0;
         winner        <= '0;
         winner_count  <= '0;
         tie           <= 1'b0;
         invalid_count <= '0;
      end else begin
         ballot_ready <= (state_nxt == COLLECT);
         done         <= (state_nxt == DONE);
         if (clr) begin
            winner        <= '0;
            winner_count  <= '0;
            tie           <= 1'b0;
            invalid_count <= '0;
         end else if (state == RESOLVE && scan_last) begin
            winner        <= win_onehot;
            winner_count  <= best_max;
            tie           <= best_tie;
            invalid_count <= inv_cnt;
         end
      end
   end

endmodule

// File: tb/tb_voting_tally.sv
// Random and directed elections on two widths (8-bit and saturating 2-bit tallies)
// compared every cycle against an election-level reference model.
module tb_voting_tally;

   localparam int NC = 3;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, ballot_valid = 1'b0, close = 1'b0;
   logic [NC-1:0] ballot = '0;
   logic          rdy_a, tie_a, done_a, rdy_b, tie_b, done_b;
   logic [NC-1:0] win_a, win_b;
   logic [7:0]    wc_a, inv_a;
   logic [1:0]    wc_b, inv_b;
   int            n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   voting_tally #(.NUM_CAND(NC), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .ballot_valid(ballot_valid), .ballot(ballot),
      .ballot_ready(rdy_a), .close(close), .winner(win_a), .winner_count(wc_a), .tie(tie_a),
      .invalid_count(inv_a), .done(done_a));

   voting_tally #(.NUM_CAND(NC), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .ballot_valid(ballot_valid), .ballot(ballot),
      .ballot_ready(rdy_b), .close(close), .winner(win_b), .winner_count(wc_b), .tie(tie_b),
      .invalid_count(inv_b), .done(done_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (index 0: 8-bit, index 1: 2-bit) ----------------
   int            ph, rcnt;        // 0 idle, 1 collecting, 2 resolving, 3 results shown
   int            t [2][NC];
   int            inv [2];
   int            e_wc [2], e_inv [2];
   logic [NC-1:0] e_win [2];
   logic          e_tie [2];

   function automatic int lim(input int w);
      return (w == 0) ? 255 : 3;
   endfunction

   task automatic m_clear_tally();
      for (int w = 0; w < 2; w++) begin
         inv[w] = 0;
         for (int i = 0; i < NC; i++) t[w][i] = 0;
      end
   endtask

   task automatic m_clear_res();
      for (int w = 0; w < 2; w++) begin
         e_win[w] = '0; e_wc[w] = 0; e_inv[w] = 0; e_tie[w] = 1'b0;
      end
   endtask

   task automatic m_reset();
      ph = 0; rcnt = 0;
      m_clear_tally();
      m_clear_res();
   endtask

   task automatic m_count(input logic [NC-1:0] b);
      for (int w = 0; w < 2; w++) begin
         if ($countones(b) == 1) begin
            for (int i = 0; i < NC; i++) if (b[i] && t[w][i] < lim(w)) t[w][i]++;
         end else if (inv[w] < lim(w)) inv[w]++;
      end
   endtask

   // Winner = highest-indexed candidate holding the maximum; tie if more than one holds it.
   task automatic m_resolve();
      for (int w = 0; w < 2; w++) begin
         int mx = 0, n = 0, top = 0;
         for (int i = 0; i < NC; i++) if (t[w][i] > mx) mx = t[w][i];
         for (int i = 0; i < NC; i++) if (t[w][i] == mx) begin n++; top = i; end
         e_wc[w]  = mx;
         e_inv[w] = inv[w];
         e_win[w] = (mx == 0) ? '0 : (NC'(1) << top);
         e_tie[w] = (mx != 0) && (n > 1);
      end
   endtask

   task automatic m_step();
      case (ph)
         0: if (start) begin m_clear_tally(); ph = 1; end
         1: if (start) m_clear_tally();
            else begin
               if (ballot_valid) m_count(ballot);
               if (close) begin ph = 2; rcnt = NC + 1; end
            end
         2: begin
               rcnt--;
               if (rcnt == 0) begin m_resolve(); ph = 3; end
            end
         3: if (start) begin m_clear_tally(); m_clear_res(); ph = 1; end
         default: ph = 0;
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else        m_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      chk("ready_a", 32'(rdy_a),  32'(ph == 1));
      chk("done_a",  32'(done_a), 32'(ph == 3));
      chk("win_a",   32'(win_a),  32'(e_win[0]));
      chk("wc_a",    32'(wc_a),   32'(e_wc[0]));
      chk("tie_a",   32'(tie_a),  32'(e_tie[0]));
      chk("inv_a",   32'(inv_a),  32'(e_inv[0]));
      chk("ready_b", 32'(rdy_b),  32'(ph == 1));
      chk("done_b",  32'(done_b), 32'(ph == 3));
      chk("win_b",   32'(win_b),  32'(e_win[1]));
      chk("wc_b",    32'(wc_b),   32'(e_wc[1]));
      chk("tie_b",   32'(tie_b),  32'(e_tie[1]));
      chk("inv_b",   32'(inv_b),  32'(e_inv[1]));
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic s, input logic v, input logic [NC-1:0] b, input logic c);
      start = s; ballot_valid = v; ballot = b; close = c;
      @(negedge clk);
      start = 1'b0; ballot_valid = 1'b0; close = 1'b0;
   endtask

   task automatic vote(input logic [NC-1:0] b);
      cyc(1'b0, 1'b1, b, 1'b0);
   endtask

   // Close (optionally with a ballot), optionally poke start during the scan, wait for done.
   task automatic close_wait(input logic v, input logic [NC-1:0] b, input logic poke);
      int lat = 0;
      cyc(1'b0, v, b, 1'b1);
      while (!done_a && lat < 20) begin
         start = poke && (lat == 0);
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      chk("close_to_done_latency", 32'(lat), 32'(NC + 1));
   endtask

   task automatic expect_a(input string nm, input logic [NC-1:0] w, input int wc,
                           input logic tf, input int iv);
      chk({nm, "_winner"},  32'(win_a), 32'(w));
      chk({nm, "_count"},   32'(wc_a),  32'(wc));
      chk({nm, "_tie"},     32'(tie_a), 32'(tf));
      chk({nm, "_invalid"}, 32'(inv_a), 32'(iv));
   endtask

   initial begin
      logic [NC-1:0] b;
      int            n;
      repeat (2) @(negedge clk);
      expect_a("reset", 'b000, 0, 1'b0, 0);
      chk("reset_ready", 32'(rdy_a), 0);
      chk("reset_done",  32'(done_a), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 2-2 tie between 100 and 010 goes to the higher index
      cyc(1'b1, 1'b0, '0, 1'b0);
      chk("ready_after_start", 32'(rdy_a), 1);
      vote('b100); vote('b100); vote('b010); vote('b010); vote('b001);
      close_wait(1'b0, '0, 1'b0);
      expect_a("s1", 'b100, 2, 1'b1, 0);

      // start from DONE clears results
      cyc(1'b1, 1'b0, '0, 1'b0);
      chk("s2_done_cleared", 32'(done_a), 0);
      chk("s2_win_cleared",  32'(win_a), 0);
      chk("s2_ready",        32'(rdy_a), 1);
      vote('b100); vote('b100); vote('b010); vote('b001); vote('b001); vote('b001);
      close_wait(1'b0, '0, 1'b0);
      expect_a("s2", 'b001, 3, 1'b0, 0);

      cyc(1'b1, 1'b0, '0, 1'b0);
      vote('b000); vote('b110); vote('b010);
      close_wait(1'b0, '0, 1'b0);
      expect_a("s3", 'b010, 1, 1'b0, 2);

      cyc(1'b1, 1'b0, '0, 1'b0);
      close_wait(1'b0, '0, 1'b0);
      expect_a("s4_empty", 'b000, 0, 1'b0, 0);

      // saturation on the 2-bit instance
      cyc(1'b1, 1'b0, '0, 1'b0);
      repeat (10) vote('b001);
      close_wait(1'b0, '0, 1'b0);
      expect_a("s5", 'b001, 10, 1'b0, 0);
      chk("s5_sat_count_b", 32'(wc_b), 3);
      chk("s5_sat_win_b",   32'(win_b), 'b001);

      // ballot with close counts; activity in DONE is ignored
      cyc(1'b1, 1'b0, '0, 1'b0);
      vote('b010);
      close_wait(1'b1, 'b100, 1'b0);
      expect_a("s6", 'b100, 1, 1'b1, 0);
      repeat (4) cyc(1'b0, 1'b1, 'b001, 1'b1);
      expect_a("s6_hold", 'b100, 1, 1'b1, 0);
      chk("s6_hold_done", 32'(done_a), 1);

      // restart in COLLECT drops the same-cycle ballot; start during scan is ignored
      cyc(1'b1, 1'b0, '0, 1'b0);
      vote('b001); vote('b001);
      cyc(1'b1, 1'b1, 'b001, 1'b0);
      vote('b010);
      close_wait(1'b0, '0, 1'b1);
      expect_a("s7", 'b010, 1, 1'b0, 0);

      // asynchronous reset during the scan
      cyc(1'b1, 1'b0, '0, 1'b0);
      vote('b010); vote('b010); vote('b100);
      cyc(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      expect_a("s8_async_rst", 'b000, 0, 1'b0, 0);
      chk("s8_rst_done",  32'(done_a), 0);
      chk("s8_rst_ready", 32'(rdy_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc(1'b1, 1'b0, '0, 1'b0);
      vote('b010); vote('b010);
      close_wait(1'b0, '0, 1'b0);
      expect_a("s8_after", 'b010, 2, 1'b0, 0);

      // random elections
      repeat (40) begin
         cyc(1'b1, 1'b0, '0, 1'b0);
         n = $urandom_range(0, 14);
         repeat (n) begin
            b = NC'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) b = NC'(1) << $urandom_range(0, NC - 1);
            cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), b, 1'b0);
         end
         close_wait(1'($urandom_range(0, 1)), NC'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 3))
            cyc(1'b0, 1'($urandom_range(0, 1)), NC'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
